// File: rtl/vec_cache_wr_tag_sched.sv
// Write-tag scheduler: allocates miss entries, issues tag writes round-robin, flags set conflicts.
// Optional same-cycle alloc->tag_wr bypass when VEC_CACHE_WR_TAG_SCHED_BYPASS_EN is defined.
module vec_cache_wr_tag_sched #(
  parameter int unsigned ENTRY_NUM = 4,
  parameter int unsigned WAY_NUM   = 8,
  parameter int unsigned INDEX_W   = 8,
  parameter int unsigned TAG_W     = 20,
  parameter int unsigned ID_W      = $clog2(ENTRY_NUM),
  localparam int unsigned WAY_W    = $clog2(WAY_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_vld,
  output logic               alloc_rdy,
  input  logic [INDEX_W-1:0] alloc_index,
  input  logic [TAG_W-1:0]   alloc_tag,
  input  logic [WAY_W-1:0]   alloc_way,
  output logic [ID_W-1:0]    alloc_id,
  output logic               tag_wr_vld,
  input  logic               tag_wr_rdy,
  output logic [INDEX_W-1:0] tag_wr_index,
  output logic [TAG_W-1:0]   tag_wr_tag,
  output logic [WAY_W-1:0]   tag_wr_way,
  output logic [ID_W-1:0]    tag_wr_id,
  input  logic               done_vld,
  input  logic [ID_W-1:0]    done_id,
  input  logic [INDEX_W-1:0] lkp_index,
  output logic               lkp_conflict,
  output logic [ENTRY_NUM-1:0] entry_busy,
  output logic [ID_W:0]      busy_cnt
);

  typedef enum logic [1:0] {StFree, StPend, StWritten} entry_st_e;

  entry_st_e          r_state [ENTRY_NUM];
  logic [INDEX_W-1:0] r_index [ENTRY_NUM];
  logic [TAG_W-1:0]   r_tag   [ENTRY_NUM];
  logic [WAY_W-1:0]   r_way   [ENTRY_NUM];
  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_lat_vld;
  logic [ID_W-1:0]    r_lat_id;

  entry_st_e          w_state_d [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] w_busy;
  logic               w_free_any;
  logic [ID_W-1:0]    w_free_id;
  logic               w_alloc_conf;
  logic               w_lkp_conf;
  logic [ID_W:0]      w_cnt;
  logic               w_alloc_fire;
  logic               w_sel_vld;
  logic [ID_W-1:0]    w_sel_id;
  logic [ID_W-1:0]    w_scan;
  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_bypass;
  logic               w_wr_fire;

  // Descending scans so the last hit is the lowest id / nearest to rr_ptr.
  always_comb begin
    w_busy       = '0;
    w_free_any   = 1'b0;
    w_free_id    = '0;
    w_alloc_conf = 1'b0;
    w_lkp_conf   = 1'b0;
    w_cnt        = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (r_state[i] == StFree) begin
        w_free_any = 1'b1;
        w_free_id  = ID_W'(i);
      end else begin
        w_busy[i] = 1'b1;
        if (r_index[i] == alloc_index) w_alloc_conf = 1'b1;
        if (r_index[i] == lkp_index)   w_lkp_conf   = 1'b1;
      end
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_cnt = w_cnt + (ID_W+1)'(w_busy[i]);
    end
  end

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_id  = '0;
    w_scan    = '0;
    for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
      w_scan = r_rr_ptr + ID_W'(k);
      if (r_state[w_scan] == StPend) begin
        w_sel_vld = 1'b1;
        w_sel_id  = w_scan;
      end
    end
  end

  assign alloc_rdy    = w_free_any & ~w_alloc_conf;
  assign alloc_id     = w_free_id;
  assign w_alloc_fire = alloc_vld & alloc_rdy;

  // A latched grant always wins so the payload holds until accepted.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_bypass  = 1'b0;
    if (r_lat_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lat_id;
    end else if (w_sel_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_sel_id;
    end
`ifdef VEC_CACHE_WR_TAG_SCHED_BYPASS_EN
    else if (w_alloc_fire) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_free_id;
      w_bypass  = 1'b1;
    end
`endif
  end

  assign w_wr_fire    = w_gnt_vld & tag_wr_rdy;
  assign tag_wr_vld   = w_gnt_vld;
  assign tag_wr_id    = w_gnt_id;
  assign tag_wr_index = w_bypass ? alloc_index : r_index[w_gnt_id];
  assign tag_wr_tag   = w_bypass ? alloc_tag   : r_tag[w_gnt_id];
  assign tag_wr_way   = w_bypass ? alloc_way   : r_way[w_gnt_id];

  assign lkp_conflict = w_lkp_conf;
  assign entry_busy   = w_busy;
  assign busy_cnt     = w_cnt;

  // Alloc hits a FREE entry, issue a PEND one, done a WRITTEN one: never the same entry.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_state_d[i] = r_state[i];
    end
    if (w_alloc_fire) begin
      w_state_d[w_free_id] = (w_bypass && tag_wr_rdy) ? StWritten : StPend;
    end
    if (w_wr_fire && !w_bypass) begin
      w_state_d[w_gnt_id] = StWritten;
    end
    if (done_vld && r_state[done_id] == StWritten) begin
      w_state_d[done_id] = StFree;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_state[i] <= StFree;
      end
      r_rr_ptr  <= '0;
      r_lat_vld <= 1'b0;
      r_lat_id  <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_state[i] <= w_state_d[i];
      end
      if (w_wr_fire) begin
        r_rr_ptr  <= w_gnt_id + ID_W'(1);
        r_lat_vld <= 1'b0;
      end else if (w_gnt_vld) begin
        r_lat_vld <= 1'b1;
        r_lat_id  <= w_gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_index[w_free_id] <= alloc_index;
      r_tag[w_free_id]   <= alloc_tag;
      r_way[w_free_id]   <= alloc_way;
    end
  end

endmodule

// File: doc/vec_cache_wr_tag_sched.md
# vec_cache_wr_tag_sched

Write-tag scheduler for the vector cache miss path. It owns a small pool of write-tag buffer entries. Each entry holds an index, a tag and a victim way. The block allocates an entry on each accepted miss and issues the tag-array writes through a single valid/ready write port with round-robin fairness. It holds each entry until the line-fill completes, so it can flag set conflicts to the lookup pipeline. It sits between the tag-lookup/evict stage and the tag SRAM write port.

## Interface
- ENTRY_NUM, 4: number of write-tag buffer entries (power of 2, ≥2)
- WAY_NUM, 8: cache ways
- INDEX_W, 8: set index width
- TAG_W, 20: tag width
- ID_W, $clog2(ENTRY_NUM): entry id width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_vld  in  1  miss requests an entry
- alloc_rdy  out  1  entry can be allocated this cycle
- alloc_index  in  INDEX_W  set index of miss
- alloc_tag  in  TAG_W  new tag
- alloc_way  in  $clog2(WAY_NUM)  victim way
- alloc_id  out  ID_W  id granted on the handshake cycle
- tag_wr_vld  out  1  tag write pending
- tag_wr_rdy  in  1  tag SRAM accepts write
- tag_wr_index / tag_wr_tag / tag_wr_way / tag_wr_id  out  INDEX_W / TAG_W / $clog2(WAY_NUM) / ID_W  write payload
- done_vld  in  1  line-fill for an entry complete
- done_id  in  ID_W  entry to release
- lkp_index  in  INDEX_W  index under lookup
- lkp_conflict  out  1  some non-FREE entry holds lkp_index (combinational)
- entry_busy  out  ENTRY_NUM  per-entry non-FREE bitmap
- busy_cnt  out  ID_W+1  number of non-FREE entries

## Operation
- Each entry has a state: FREE, PEND (tag write not yet done) or WRITTEN (tag written, fill outstanding).
- Allocate:
  - alloc_rdy = (any FREE entry) AND (no non-FREE entry has index == alloc_index).
  - This allows only one outstanding miss per set.
  - On alloc_vld&alloc_rdy, the lowest-numbered FREE entry captures index/tag/way and goes FREE→PEND.
  - alloc_id shows that entry's number combinationally.
- Issue:
  - A round-robin pointer selects the first PEND entry at or after rr_ptr (wrapping).
  - tag_wr_vld = a selection exists.
  - On the tag_wr handshake, the entry goes PEND→WRITTEN and rr_ptr becomes (granted id + 1) mod ENTRY_NUM.
- Payload hold: once tag_wr_vld is high and tag_wr_rdy is low, the grant is latched. tag_wr_vld and the payload stay constant until the handshake, even if new PEND entries appear.
- Release:
  - done_vld with done_id in WRITTEN moves that entry WRITTEN→FREE.
  - done_vld on a FREE or PEND entry is ignored; no state change.
- busy_cnt is the population count of entry_busy.
- There is no other state machine; each entry transitions at most once per cycle.

## Timing
- Reset values: all entries FREE, rr_ptr=0, tag_wr_vld=0, alloc_rdy=1 (given no conflict), entry_busy=0, busy_cnt=0, lkp_conflict=0, grant latch clear.
- Reset mid-operation drops all entries immediately; in-flight tag writes are not completed.
- Alloc handshake at cycle T: entry is PEND at T+1; earliest tag_wr_vld is T+1, or T when the bypass is built in (see Configuration).
- Tag write handshake at T: entry is WRITTEN at T+1.
- done at T: entry is FREE at T+1. alloc_rdy can reflect the freed entry no earlier than T+1; there is no same-cycle reuse.
- Simultaneous done_id == tag_wr_id handshake on a PEND entry: done is ignored and the entry becomes WRITTEN.
- Full pool (busy_cnt == ENTRY_NUM): alloc_rdy=0 and alloc_id is don't-care.
- lkp_conflict and the alloc set check use the registered state only; an alloc in the same cycle is not visible until T+1.

## Configuration
- VEC_CACHE_WR_TAG_SCHED_BYPASS_EN, defined: bypass is built in.
  - If no entry is PEND and no grant is latched, an accepted alloc drives tag_wr_vld and its payload in the same cycle.
  - If tag_wr_rdy is high that cycle, the entry goes FREE→WRITTEN directly and rr_ptr advances past it.
  - If tag_wr_rdy is low, the entry goes to PEND and the grant is latched, so the payload holds.
- Undefined: no bypass; tag_wr outputs depend only on registered state. Minimum alloc→tag_wr latency is 1 cycle.

## Test plan
- Reset, then allocate index 0x10, tag 0x12345, way 3 with tag_wr_rdy=1 → alloc_id=0; tag_wr_vld at T+1 (T with bypass) with matching payload; entry_busy=0b0001; busy_cnt=1.
- Fill all 4 entries on distinct indices with tag_wr_rdy=0 → alloc_rdy=0 at busy_cnt=4. Release tag_wr_rdy → grants in id order 0,1,2,3, and the payload is held while rdy is low.
- Entry holds index 0x20 in WRITTEN; present alloc on 0x20 and lkp_index=0x20 → alloc_rdy=0 and lkp_conflict=1. done for that id → both clear the next cycle.
- done_vld on a PEND id 1 in the same cycle as its tag_wr handshake → entry 1 is WRITTEN, not FREE; busy_cnt unchanged.
- Fairness: entries 0 and 2 PEND, rr_ptr=1 → entry 2 is granted first, then 0.
- Assert rst with 3 busy entries and tag_wr_vld high → all outputs return to their reset values asynchronously.
